servo_pwm_decoder: RTL and testbench

SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

---
 rtl/servo_pwm_pkg.sv | 11 +
 rtl/pwm_capture_channel.sv | 107 ++++++++++
 rtl/servo_pwm_decoder.sv | 48 ++++
 tb/tb_servo_pwm_decoder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: shared FSM state type, angle scale factor and default timing for the servo PWM decoder
package servo_pwm_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} pwm_state_t;
  // 180 deg / 2000 us in Q16.16 (0.09 * 65536, truncated)
  localparam logic [31:0] DEG_PER_US_Q16 = 32'd5898;
  localparam int DEF_TICKS_PER_US = 100;
  localparam int DEF_MIN_US = 500;
  localparam int DEF_MAX_US = 2500;
  localparam int DEF_TIMEOUT_US = 40000;
  localparam int DEF_CATCH_TH_US = 1500;
endpackage

// File: rtl/pwm_capture_channel.sv
// pwm_capture_channel: measures one servo PWM high time in whole us and turns it into a result
// Ports: clk, rstn (async, active-low), pwm (raw input);
//   value (Q16.16 angle, or the catch-closed bit when CATCH=1), upd/err_range (one-cycle strobes), valid (level).
// Macro PWM_DEC_SYNC_EN inserts a 2-flop synchronizer ahead of the edge register (+2 clk latency).
// Result timing: the fall is visible to the FSM in cycle C; width is latched at the end of C,
// and value/upd/err_range change one clk later, i.e. 2 clk after C.
module pwm_capture_channel
  import servo_pwm_pkg::*;
#(
  parameter int TICKS_PER_US = DEF_TICKS_PER_US,
  parameter int MIN_US = DEF_MIN_US,
  parameter int MAX_US = DEF_MAX_US,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int CATCH_TH_US = DEF_CATCH_TH_US,
  parameter bit CATCH = 1'b0,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         pwm,
  output logic [W-1:0] value,
  output logic         upd,
  output logic         valid,
  output logic         err_range
);
  localparam int PW = TICKS_PER_US > 1 ? $clog2(TICKS_PER_US) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_US - 1);
  logic s;
`ifdef PWM_DEC_SYNC_EN
  localparam int ARM = 3;
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sync <= '0;
    else sync <= {sync[0], pwm};
  assign s = sync[1];
`else
  localparam int ARM = 1;
  assign s = pwm;
`endif
  pwm_state_t state;
  logic [ARM-1:0] arm;
  logic prev, done, rise, fall, wrap, t_wrap, tmo, in_range;
  logic [PW-1:0] pre, t_pre;
  logic [15:0] width_us, t_us, width_l, width_f;
  logic [31:0] angle;
  // arm blocks edge detection until the cleared input path has refilled after reset,
  // so an input already high at release is not mistaken for a rising edge
  assign rise = arm[ARM-1] & s & ~prev;
  assign fall = ~s & prev;
  assign wrap = pre == LAST;
  assign t_wrap = t_pre == LAST;
  assign tmo = state != IDLE && t_us == 16'(TIMEOUT_US);
  // the current cycle completes a microsecond when the prescaler sits at its last count
  assign width_f = (wrap && width_us != 16'hFFFF) ? width_us + 16'd1 : width_us;
  assign in_range = width_l >= 16'(MIN_US) && width_l <= 16'(MAX_US);
  assign angle = (32'(width_l) - 32'(MIN_US)) * DEG_PER_US_Q16;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      arm <= '0;
      prev <= 1'b0;
      done <= 1'b0;
      pre <= '0;
      t_pre <= '0;
      width_us <= '0;
      t_us <= '0;
      width_l <= '0;
      value <= '0;
      upd <= 1'b0;
      valid <= 1'b0;
      err_range <= 1'b0;
    end else begin
      arm <= ARM'({arm, 1'b1});
      prev <= s;
      done <= 1'b0;
      upd <= 1'b0;
      err_range <= 1'b0;
      if (done) begin
        if (CATCH || in_range) value <= CATCH ? W'(width_l >= 16'(CATCH_TH_US)) : W'(angle);
        upd <= in_range;
        err_range <= ~in_range;
        if (in_range) valid <= 1'b1;
      end
      if (rise) begin
        state <= HIGH;
        pre <= '0;
        t_pre <= '0;
        width_us <= '0;
        t_us <= '0;
      end else if (tmo) begin
        state <= IDLE;
        valid <= 1'b0;
      end else if (state != IDLE) begin
        t_pre <= t_wrap ? '0 : t_pre + PW'(1);
        if (t_wrap) t_us <= t_us + 16'd1;
        if (state == HIGH && fall) begin
          state <= LOW;
          done <= 1'b1;
          width_l <= width_f;
        end else if (state == HIGH) begin
          pre <= wrap ? '0 : pre + PW'(1);
          width_us <= width_f;
        end
      end
    end
  end
endmodule

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: decodes two joint servo PWM inputs into Q16.16 angles and a gripper PWM into a catch bit
// Ports: clk, rstn (async, active-low), pwm1/pwm2 (joint PWM), catch_pwm (gripper PWM);
//   xita1/xita2 (angle in degrees, Q16.16), catch (1 = closed),
//   upd/valid/err_range (bit order {catch, xita2, xita1}).
// Macro PWM_DEC_SYNC_EN adds a 2-flop synchronizer per input (latency 4 clk instead of 2).
module servo_pwm_decoder
  import servo_pwm_pkg::*;
#(
  parameter int TICKS_PER_US = DEF_TICKS_PER_US,
  parameter int MIN_US = DEF_MIN_US,
  parameter int MAX_US = DEF_MAX_US,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int CATCH_TH_US = DEF_CATCH_TH_US
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pwm1,
  input  logic        pwm2,
  input  logic        catch_pwm,
  output logic [31:0] xita1,
  output logic [31:0] xita2,
  output logic        catch,
  output logic [2:0]  upd,
  output logic [2:0]  valid,
  output logic [2:0]  err_range
);
  pwm_capture_channel #(
    .TICKS_PER_US(TICKS_PER_US), .MIN_US(MIN_US), .MAX_US(MAX_US),
    .TIMEOUT_US(TIMEOUT_US), .CATCH_TH_US(CATCH_TH_US), .CATCH(1'b0), .W(32)
  ) u_ch1 (
    .clk(clk), .rstn(rstn), .pwm(pwm1), .value(xita1),
    .upd(upd[0]), .valid(valid[0]), .err_range(err_range[0])
  );
  pwm_capture_channel #(
    .TICKS_PER_US(TICKS_PER_US), .MIN_US(MIN_US), .MAX_US(MAX_US),
    .TIMEOUT_US(TIMEOUT_US), .CATCH_TH_US(CATCH_TH_US), .CATCH(1'b0), .W(32)
  ) u_ch2 (
    .clk(clk), .rstn(rstn), .pwm(pwm2), .value(xita2),
    .upd(upd[1]), .valid(valid[1]), .err_range(err_range[1])
  );
  pwm_capture_channel #(
    .TICKS_PER_US(TICKS_PER_US), .MIN_US(MIN_US), .MAX_US(MAX_US),
    .TIMEOUT_US(TIMEOUT_US), .CATCH_TH_US(CATCH_TH_US), .CATCH(1'b1), .W(1)
  ) u_catch (
    .clk(clk), .rstn(rstn), .pwm(catch_pwm), .value(catch),
    .upd(upd[2]), .valid(valid[2]), .err_range(err_range[2])
  );
endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb_servo_pwm_decoder: random and directed pulse rounds checked against an arithmetic model of the decoder
module tb_servo_pwm_decoder;
  localparam int T = 2, MIN = 500, MAX = 2500, TMO = 6000, CTH = 1500;
`ifdef PWM_DEC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [2:0] pw = '0;
  logic [31:0] xita1, xita2;
  logic catch;
  logic [2:0] upd, valid, err_range;
  int checks = 0;
  int errors = 0;
  int nu[3], ne[3], eu[3], ee[3];
  logic [31:0] ex[2];
  logic ec;
  logic [2:0] ev;

  servo_pwm_decoder #(
    .TICKS_PER_US(T), .MIN_US(MIN), .MAX_US(MAX), .TIMEOUT_US(TMO), .CATCH_TH_US(CTH)
  ) dut (
    .clk(clk), .rstn(rstn), .pwm1(pw[0]), .pwm2(pw[1]), .catch_pwm(pw[2]),
    .xita1(xita1), .xita2(xita2), .catch(catch),
    .upd(upd), .valid(valid), .err_range(err_range)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      nu[i] += int'(upd[i]);
      ne[i] += int'(err_range[i]);
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one pulse of hc high cycles then lc low cycles; rec=1 folds the result into the model,
  // rec=0 marks a pulse that must produce no strobe at all
  task automatic pulse(input int ch, input int hc, input int lc, input bit rec);
    int w, lat;
    bit inr;
    w = hc / T;
    if (w > 65535) w = 65535;
    inr = w >= MIN && w <= MAX;
    @(posedge clk);
    #1 pw[ch] = 1'b1;
    repeat (hc) @(posedge clk);
    #1 pw[ch] = 1'b0;
    lat = 0;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && (upd[ch] || err_range[ch])) lat = k;
    end
    check($sformatf("latency ch%0d w=%0d", ch, w), lat, rec ? LAT : 0);
    if (rec) begin
      if (inr) begin
        if (ch < 2) ex[ch] = 32'((w - MIN) * 5898);
        ev[ch] = 1'b1;
      end
      if (ch == 2) ec = w >= CTH;
      eu[ch] += int'(inr);
      ee[ch] += int'(!inr);
    end
    repeat (lc - (LAT + 2)) @(posedge clk);
  endtask

  task automatic round(input int h0, input int h1, input int h2, input int lc, input bit rec);
    fork
      pulse(0, h0, lc, rec);
      pulse(1, h1, lc, rec);
      pulse(2, h2, lc, rec);
    join
  endtask

  task automatic check_round(input string tag);
    check({tag, " xita1"}, xita1, ex[0]);
    check({tag, " xita2"}, xita2, ex[1]);
    check({tag, " catch"}, 32'(catch), 32'(ec));
    check({tag, " valid"}, 32'(valid), 32'(ev));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s upd%0d count", tag, i), nu[i], eu[i]);
      check($sformatf("%s err%0d count", tag, i), ne[i], ee[i]);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " xita1"}, xita1, 0);
    check({tag, " xita2"}, xita2, 0);
    check({tag, " catch"}, 32'(catch), 0);
    check({tag, " upd"}, 32'(upd), 0);
    check({tag, " valid"}, 32'(valid), 0);
    check({tag, " err"}, 32'(err_range), 0);
  endtask

  initial begin
    ex[0] = '0;
    ex[1] = '0;
    ec = 1'b0;
    ev = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rstn = 1'b1;
    round(500 * T, 1500 * T, 2000 * T, 200 * T, 1'b1);
    check_round("r1 min");
    round(1500 * T, 2500 * T, 1000 * T, 200 * T, 1'b1);
    check_round("r2 mid/max");
    check("r2 xita1 literal", xita1, 32'h0059_FF10);
    check("r2 xita2 literal", xita2, 32'h00B3_FE20);
    round(2500 * T + T - 1, 3000 * T, 1500 * T, 200 * T, 1'b1);
    check_round("r3 trunc/over");
    round(500 * T - 1, 2501 * T, 400 * T, 200 * T, 1'b1);
    check_round("r4 bounds");
    round(1800 * T, 1800 * T, 1800 * T, 200 * T, 1'b1);
    check_round("r5 simultaneous");
    repeat ((TMO + 500) * T) @(posedge clk);
    #1 ev = '0;
    check_round("timeout");
    round(1000 * T, 1000 * T, 1000 * T, 200 * T, 1'b1);
    check_round("restore");
    for (int r = 0; r < 3; r++) begin
      round(int'($urandom_range(400 * T, 3000 * T)), int'($urandom_range(400 * T, 3000 * T)),
            int'($urandom_range(400 * T, 3000 * T)), int'($urandom_range(100 * T, 300 * T)), 1'b1);
      check_round($sformatf("random%0d", r));
    end
    fork
      round(1500 * T, 1500 * T, 1500 * T, 200 * T, 1'b0);
      begin
        repeat (700 * T) @(posedge clk);
        #1 rstn = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_zero("mid-pulse reset");
        rstn = 1'b1;
      end
    join
    ex[0] = '0;
    ex[1] = '0;
    ec = 1'b0;
    ev = '0;
    check_round("after reset");
    round(1200 * T, 2000 * T, 1600 * T, 200 * T, 1'b1);
    check_round("post reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
